// File: rtl/bram_rd_arbiter_if.sv
// Read-request, response and write-through bundle between memory clients and bram_rd_arbiter.
interface bram_rd_arbiter_if #(
  parameter int NUM_CLIENTS = 3,
  parameter int ADDR_WIDTH  = 4,
  parameter int DATA_WIDTH  = 8
);
  logic [NUM_CLIENTS-1:0]            rd_req;
  logic [NUM_CLIENTS*ADDR_WIDTH-1:0] rd_addr;
  logic [NUM_CLIENTS-1:0]            rd_gnt;
  logic [NUM_CLIENTS-1:0]            rsp_valid;
  logic [DATA_WIDTH-1:0]             rsp_data;
  logic                              wr_en;
  logic [ADDR_WIDTH-1:0]             wr_addr;
  logic [DATA_WIDTH-1:0]             wr_data;

  modport master (
    output rd_req, rd_addr, wr_en, wr_addr, wr_data,
    input  rd_gnt, rsp_valid, rsp_data
  );

  modport slave (
    input  rd_req, rd_addr, wr_en, wr_addr, wr_data,
    output rd_gnt, rsp_valid, rsp_data
  );
endinterface

// File: rtl/bram_rd_arbiter.sv
// Round-robin share of one bram_1r1w read port; fixed 1-cycle response latency.
// No request buffering: ungranted clients hold their request, writes are never stalled.

module bram_1r1w #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  // Read samples the array before this edge's write lands: old data on collision.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end
endmodule

module bram_rd_arbiter #(
  parameter int NUM_CLIENTS = 3,
  parameter int ADDR_WIDTH  = 4,
  parameter int DATA_WIDTH  = 8,
  parameter bit BYPASS      = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  bram_rd_arbiter_if.slave  bus
);
  localparam int PW = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;

  logic [PW-1:0]          rr_ptr;
  logic [PW-1:0]          gnt_idx;
  logic                   gnt_any;
  logic [NUM_CLIENTS-1:0] gnt;
  logic [ADDR_WIDTH-1:0]  ram_rd_addr;
  logic [DATA_WIDTH-1:0]  ram_q;
  logic                   collide;
  logic                   fwd_hit;
  logic [DATA_WIDTH-1:0]  fwd_data;

  // Scan from rr_ptr upward, wrapping explicitly so non-power-of-2 counts work.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      int idx;
      idx = int'(rr_ptr) + i;
      if (idx >= NUM_CLIENTS) idx = idx - NUM_CLIENTS;
      if (!gnt_any && bus.rd_req[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = PW'(idx);
      end
    end
  end

  always_comb begin
    gnt = '0;
    if (gnt_any) gnt[gnt_idx] = 1'b1;
  end

  assign bus.rd_gnt  = gnt;
  assign ram_rd_addr = bus.rd_addr[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
  assign collide     = BYPASS && gnt_any && bus.wr_en && (bus.wr_addr == ram_rd_addr);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr        <= '0;
      bus.rsp_valid <= '0;
      fwd_hit       <= 1'b0;
      fwd_data      <= '0;
    end else begin
      if (gnt_any) begin
        rr_ptr <= (gnt_idx == PW'(NUM_CLIENTS - 1)) ? '0 : gnt_idx + PW'(1);
      end
      bus.rsp_valid <= gnt;
      fwd_hit       <= collide;
      if (collide) fwd_data <= bus.wr_data;
    end
  end

  bram_1r1w #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_ram (
    .clk     (clk),
    .wr_en   (bus.wr_en),
    .wr_addr (bus.wr_addr),
    .wr_data (bus.wr_data),
    .rd_addr (ram_rd_addr),
    .rd_data (ram_q)
  );

  assign bus.rsp_data = fwd_hit ? fwd_data : ram_q;
endmodule

// File: doc/bram_rd_arbiter.md
Name: bram_rd_arbiter

Overview:
- Shares the single read port of one internally instantiated bram_1r1w between NUM_CLIENTS requesters using round-robin arbitration.
- The write port passes straight through from a single writer.
- Optional write-to-read forwarding hides the RAM's old-data-on-collision behaviour.
- Sits between the traversal/shading units and shared scene or stack memories.

Parameters:
- NUM_CLIENTS, 3, number of read requesters (2..8).
- ADDR_WIDTH, 4, RAM address width; depth is 2**ADDR_WIDTH.
- DATA_WIDTH, 8, RAM word width.
- BYPASS, 1, when 1, a same-cycle write to the granted read address is forwarded to the response.

Ports:
- clk  input  1  single clock; all logic rising-edge.
- reset  input  1  asynchronous, active-high reset.
- rd_req  input  NUM_CLIENTS  per-client read request.
- rd_addr  input  NUM_CLIENTS*ADDR_WIDTH  flattened per-client address; client k occupies bits [k*ADDR_WIDTH +: ADDR_WIDTH].
- rd_gnt  output  NUM_CLIENTS  one-hot, combinational grant in the request cycle.
- rsp_valid  output  NUM_CLIENTS  one-hot, response strobe for the granted client.
- rsp_data  output  DATA_WIDTH  shared response data; meaningful only while rsp_valid != 0.
- wr_en  input  1  write strobe, passed to the RAM.
- wr_addr  input  ADDR_WIDTH  write address.
- wr_data  input  DATA_WIDTH  write data.

Behaviour:
- Reset (asynchronous assert):
  - rr_ptr = 0, rsp_valid = 0, fwd_hit = 0.
  - rd_gnt follows the arbitration from rr_ptr = 0.
  - RAM contents are not cleared. rsp_data is undefined until the first response.
- Arbitration (combinational, cycle T):
  - Scan clients starting at index rr_ptr, ascending, wrapping at NUM_CLIENTS-1 to 0.
  - The first client with rd_req=1 receives rd_gnt. At most one grant per cycle.
  - With no requests, rd_gnt = 0 and the RAM read address is don't-care.
  - The granted client's address drives the RAM read address in cycle T.
- Pointer: on any grant to client g at T, rr_ptr <= (g+1) mod NUM_CLIENTS. With no grant, rr_ptr holds.
- Fairness: a continuously requesting client waits at most NUM_CLIENTS-1 grants.
- Latency: fixed 1 cycle. A grant at T gives rsp_valid[g]=1 for exactly one cycle at T+1, with rsp_data = RAM word.
- Throughput: one grant per cycle, back-to-back. The same client may be granted on consecutive cycles only if no other client is requesting.
- Client rule: a non-granted client holds rd_req and its address stable until granted. The arbiter does not buffer requests. Dropping rd_req before the grant is legal (the request is withdrawn).
- Write path: wr_en, wr_addr and wr_data go to the RAM unmodified and are never stalled. The write commits at the rising edge.
- Same-address collision (wr_en=1 and wr_addr == granted read address in the same cycle T):
  - BYPASS=1: register fwd_hit=1 and fwd_data=wr_data at T. At T+1, rsp_data = fwd_data (the new value).
  - BYPASS=0: rsp_data = old RAM value.
- Width rules: addresses compare on full ADDR_WIDTH. Index arithmetic uses $clog2(NUM_CLIENTS) bits with explicit wrap, not a power-of-2 modulo.
- Reset mid-operation: an in-flight response is dropped. rsp_valid is 0 from reset assertion and in the first cycle after release.

Test Plan:
- Reset, then a single client: preload addr 5 = 0x3C via the write port. Client 1 requests addr 5 at T → rd_gnt=3'b010 at T, rsp_valid=3'b010 and rsp_data=0x3C at T+1, all other cycles rsp_valid=0.
- Round-robin: all 3 clients hold requests from rr_ptr=0 (addrs 1,2,3 preloaded with 0x11,0x22,0x33) → grants 0,1,2,0 on consecutive cycles, responses 0x11,0x22,0x33,0x11 each one cycle later, no idle cycles.
- Fairness: client 0 requests continuously, client 2 requests at cycle 4 with rr_ptr=1 → client 2 is granted at cycle 4 (not client 0). Next cycle client 0 is granted, rr_ptr returns to 1.
- Collision with BYPASS=1: addr 7 holds 0xAA. Same cycle: wr_en to addr 7 with 0x55, and client 0 reads addr 7 → rsp_data=0x55 at T+1. Repeat with BYPASS=0 → 0xAA. A following read of addr 7 returns 0x55 in both cases.
- Reset mid-flight: grant at T, reset asserted between T and T+1 → rsp_valid=0 at T+1. After release, rr_ptr=0: clients 1 and 2 requesting → client 1 granted first.
- Idle/withdraw: client 2 asserts rd_req for one cycle while client 0 holds the grant, then drops it → no grant or response is ever issued to client 2.
